// File: rtl/siw_memory_bram_pkg.sv
// Shared types and default sizes for the BRAM port arbiter.
// State encoding is fixed so waveforms read the same across builds.
package siw_memory_bram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    localparam int AW_DEF        = 14;
    localparam int DW_DEF        = 32;
    localparam int RD_LAT_DEF    = 2;
    localparam int MAX_BURST_DEF = 8;

endpackage

// File: rtl/siw_memory_bram_arb_rdpipe.sv
// Read-return tag pipeline: carries {valid, owner} alongside the BRAM latency.
// A clear drops every in-flight read so nothing returns after reset.
module siw_memory_bram_arb_rdpipe #(
    parameter int RD_LAT = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_vld,
    input  logic i_tag,
    output logic o_rvalid0,
    output logic o_rvalid1
);

    logic [RD_LAT-1:0] r_vld;
    logic [RD_LAT-1:0] r_tag;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld <= '0;
            r_tag <= '0;
        end else begin
            r_vld[0] <= i_vld;
            r_tag[0] <= i_tag;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    assign o_rvalid0 = r_vld[RD_LAT-1] & ~r_tag[RD_LAT-1];
    assign o_rvalid1 = r_vld[RD_LAT-1] &  r_tag[RD_LAT-1];

endmodule

// File: rtl/siw_memory_bram_arb.sv
// Two-requester round-robin arbiter with bounded burst lock for one BRAM port.
// Grants are zero-cycle; read data is steered back by a tag pipeline.
module siw_memory_bram_arb
    import siw_memory_bram_pkg::*;
#(
    parameter int         AW        = AW_DEF,
    parameter int         DW        = DW_DEF,
    parameter int         RD_LAT    = RD_LAT_DEF,
    parameter int         MAX_BURST = MAX_BURST_DEF,
    parameter logic [1:0] WR_DELAY  = 2'd0
) (
    input  logic          siw_memory_bram_arb_clk,
    input  logic          siw_memory_bram_arb_reset_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          mem_enable,
    output logic          mem_write_en,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_input_data,
    output logic [1:0]    mem_conf,
    input  logic [DW-1:0] mem_output_data
);

    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] LAST = CW'(MAX_BURST - 1);

    arb_state_e    r_state;
    arb_state_e    w_next;
    logic          r_last;
    logic [CW-1:0] r_cnt;
    logic          w_gnt0;
    logic          w_gnt1;

    always_comb begin
        w_next = IDLE;
        unique case (r_state)
            IDLE: begin
                if (req0 & req1)
                    w_next = r_last ? OWN0 : OWN1;
                else if (req0)
                    w_next = OWN0;
                else if (req1)
                    w_next = OWN1;
            end
            OWN0: begin
                if (req0 & (~req1 | (r_cnt < LAST)))
                    w_next = OWN0;
                else if (req1)
                    w_next = OWN1;
            end
            OWN1: begin
                if (req1 & (~req0 | (r_cnt < LAST)))
                    w_next = OWN1;
                else if (req0)
                    w_next = OWN0;
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_gnt0 = (w_next == OWN0);
    assign w_gnt1 = (w_next == OWN1);

    always_ff @(posedge siw_memory_bram_arb_clk or negedge siw_memory_bram_arb_reset_n) begin
        if (!siw_memory_bram_arb_reset_n) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            // count only beats that keep the same owner; saturate at the lock limit
            if (w_next != IDLE && w_next == r_state) begin
                if (r_cnt != LAST)
                    r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
            if (w_gnt0)
                r_last <= 1'b0;
            else if (w_gnt1)
                r_last <= 1'b1;
        end
    end

    assign gnt0           = w_gnt0;
    assign gnt1           = w_gnt1;
    assign mem_enable     = w_gnt0 | w_gnt1;
    assign mem_write_en   = w_gnt0 ? we0    : (w_gnt1 ? we1    : 1'b0);
    assign mem_address    = w_gnt0 ? addr0  : (w_gnt1 ? addr1  : '0);
    assign mem_input_data = w_gnt0 ? wdata0 : (w_gnt1 ? wdata1 : '0);
    assign mem_conf       = WR_DELAY;
    assign rdata0         = mem_output_data;
    assign rdata1         = mem_output_data;

    siw_memory_bram_arb_rdpipe #(
        .RD_LAT (RD_LAT)
    ) u_rdpipe (
        .i_clk     (siw_memory_bram_arb_clk),
        .i_rst_n   (siw_memory_bram_arb_reset_n),
        .i_vld     (mem_enable & ~mem_write_en),
        .i_tag     (w_gnt1),
        .o_rvalid0 (rvalid0),
        .o_rvalid1 (rvalid1)
    );

endmodule

// File: doc/siw_memory_bram_arb.md
Name: siw_memory_bram_arb

Overview:
- Two-requester arbiter that shares one port of a siw_memory_bram_N instance (14-bit address, 32-bit data, 2-cycle read latency).
- Muxes requester address, data and write-enable onto the BRAM port using round-robin with a bounded burst lock.
- Steers returning read data back to the requester that issued the read.
- Sits between the datapath load/store units and the BRAM wrapper; instantiated once per shared BRAM port.

Parameters:
- AW, 14, address width
- DW, 32, data width
- RD_LAT, 2, cycles from read accept to data valid on mem_output_data (BRAM register + output register)
- MAX_BURST, 8, maximum consecutive beats granted to one owner while the other requester waits (1..256)
- WR_DELAY, 0, value driven on mem_conf (write-enable delay select); fixed at 0 so writes commit in the accept cycle

Ports:
- siw_memory_bram_arb_clk  in  1  clock
- siw_memory_bram_arb_reset_n  in  1  asynchronous active-low reset
- req0 / req1  in  1  access request
- we0 / we1  in  1  1 = write, 0 = read; qualified by req
- addr0 / addr1  in  AW  word address
- wdata0 / wdata1  in  DW  write data
- gnt0 / gnt1  out  1  beat accepted this cycle when req & gnt
- rvalid0 / rvalid1  out  1  read data valid for that requester
- rdata0 / rdata1  out  DW  read data; both carry mem_output_data, meaningful only with rvalid
- mem_enable  out  1  to BRAM enable
- mem_write_en  out  1  to BRAM write_en
- mem_address  out  AW  to BRAM address
- mem_input_data  out  DW  to BRAM input_data
- mem_conf  out  2  to BRAM mem_conf; constant WR_DELAY
- mem_output_data  in  DW  from BRAM output_data

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low (siw_memory_bram_arb_clk, siw_memory_bram_arb_reset_n).
- Reset values:
  - state = IDLE, last_owner = 1 (req0 wins the first tie), burst_cnt = 0, read pipe cleared.
  - All outputs 0, except mem_conf = WR_DELAY.
- FSM states: IDLE, OWN0, OWN1. next_state is combinational from state, req0, req1 and burst_cnt. Registered each clock.
- From IDLE:
  - Only reqk → OWNk.
  - Both requesting → OWN of the requester that is not last_owner.
  - None → IDLE.
- From OWNk (j = other requester):
  - reqk & (!reqj | burst_cnt < MAX_BURST-1) → OWNk.
  - reqj & (!reqk | burst_cnt == MAX_BURST-1) → OWNj.
  - Neither requesting → IDLE.
- Grant and memory drive:
  - gntk = (next_state == OWNk); grant is combinational, with zero-cycle accept.
  - mem_enable = gnt0 | gnt1.
  - mem_address, mem_input_data and mem_write_en are muxed from the granted requester; all are 0 when there is no grant.
- Counters and owner tracking:
  - burst_cnt increments on each beat that stays with the same owner.
  - burst_cnt loads 0 on an owner change or on entering IDLE. It saturates at MAX_BURST-1.
  - last_owner updates to k on every granted beat of requester k.
- Write path: with WR_DELAY = 0, a write commits at the clock edge of acceptance. Writes produce no rvalid.
- Read return: a read accepted at cycle t for requester k asserts rvalidk for exactly one cycle at t+RD_LAT. The tag pipeline is RD_LAT deep and fully pipelined, so back-to-back reads give back-to-back rvalid.
- Interleaving: read-after-write to the same address in consecutive beats returns the new data (BRAM write-first is relied upon). Owner switches do not stall in-flight reads; tags keep each return with its issuer.
- Reset mid-operation: in-flight reads are discarded and no rvalid is issued after reset deasserts. The grant restarts from IDLE.
- Requesters must hold addr/we/wdata stable while req is high and gnt is low. The arbiter does not check this.

Decomposition:
- Package siw_memory_bram_pkg holds:
  - state encoding: IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2
  - defaults for AW, DW, RD_LAT and MAX_BURST
- Sub-module siw_memory_bram_arb_rdpipe: RD_LAT-stage shift register of {valid, tag}, with async active-low clear. Outputs rvalid0/rvalid1.

Test Plan:
- Reset then idle: no req for 10 cycles → gnt0 = gnt1 = 0, mem_enable = 0, mem_conf = 0.
- Single reader: req0 read addr 0x0005 after a prior write of 0xDEADBEEF at cycle t → gnt0 at t, rvalid0 at t+2 with rdata0 = 0xDEADBEEF, rvalid1 stays 0.
- Tie after reset: req0 and req1 asserted together from cycle 0 for 20 cycles → first 8 beats to req0, next 8 to req1, then req0. gnt0 and gnt1 are never high together.
- Burst yield: req0 holds for 3 beats then drops while req1 has been waiting → req1 granted in the very next cycle, burst_cnt back to 0.
- Interleaved reads: alternating accepted reads to 0x0010 (owner 0) and 0x0020 (owner 1) preloaded with 0x11 and 0x22 → rvalid0 with 0x11 and rvalid1 with 0x22, each 2 cycles after its accept, in order.
- Reset mid-read: reset_n pulsed low one cycle after a read is accepted → no rvalid0/rvalid1 afterwards, state back to IDLE, next tie goes to req0.
